// File: rtl/sram_access_arbiter.sv
// Two-requester round-robin arbiter onto one registered SRAM access request stage.
// Grant order is kept in a small FIFO so in-order SRAM responses return to their issuer.
module sram_access_arbiter #(
    parameter int ORDER_DEPTH = 4
) (
    input  logic        clk,
    input  logic        clk__enable,
    input  logic        reset_n,

    input  logic        req0__valid,
    input  logic [7:0]  req0__id,
    input  logic        req0__read_not_write,
    input  logic [7:0]  req0__byte_enable,
    input  logic [31:0] req0__address,
    input  logic [63:0] req0__write_data,
    output logic        resp0__ack,
    output logic        resp0__valid,
    output logic [7:0]  resp0__id,
    output logic [63:0] resp0__data,

    input  logic        req1__valid,
    input  logic [7:0]  req1__id,
    input  logic        req1__read_not_write,
    input  logic [7:0]  req1__byte_enable,
    input  logic [31:0] req1__address,
    input  logic [63:0] req1__write_data,
    output logic        resp1__ack,
    output logic        resp1__valid,
    output logic [7:0]  resp1__id,
    output logic [63:0] resp1__data,

    output logic        sram_access_req__valid,
    output logic [7:0]  sram_access_req__id,
    output logic        sram_access_req__read_not_write,
    output logic [7:0]  sram_access_req__byte_enable,
    output logic [31:0] sram_access_req__address,
    output logic [63:0] sram_access_req__write_data,
    input  logic        sram_access_resp__ack,
    input  logic        sram_access_resp__valid,
    input  logic [7:0]  sram_access_resp__id,
    input  logic [63:0] sram_access_resp__data,

    output logic [4:0]  outstanding,
    output logic        protocol_error
);
    localparam int PTR_W = (ORDER_DEPTH > 1) ? $clog2(ORDER_DEPTH) : 1;
    localparam logic [4:0] DEPTH = 5'(ORDER_DEPTH);

    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [ORDER_DEPTH-1:0] order_mem;  // requester index recorded per grant
    logic                   last_grant;

    logic        stage_free;
    logic        can_grant;
    logic        grant0;
    logic        grant1;
    logic        push;
    logic        pop;
    logic        fifo_empty;
    logic        head;
    logic [7:0]  sel_id;
    logic        sel_rnw;
    logic [7:0]  sel_be;
    logic [31:0] sel_address;
    logic [63:0] sel_write_data;

    always_comb begin
        stage_free = !sram_access_req__valid || sram_access_resp__ack;
        can_grant  = clk__enable && stage_free && (outstanding < DEPTH);
        grant0     = can_grant && req0__valid && (!req1__valid || last_grant);
        grant1     = can_grant && req1__valid && (!req0__valid || !last_grant);
        push       = grant0 || grant1;
        fifo_empty = (outstanding == 5'd0);
        head       = order_mem[rd_ptr];
        pop        = clk__enable && sram_access_resp__valid && !fifo_empty;

        sel_id         = grant1 ? req1__id             : req0__id;
        sel_rnw        = grant1 ? req1__read_not_write : req0__read_not_write;
        sel_be         = grant1 ? req1__byte_enable    : req0__byte_enable;
        sel_address    = grant1 ? req1__address        : req0__address;
        sel_write_data = grant1 ? req1__write_data     : req0__write_data;
    end

    assign resp0__ack   = grant0;
    assign resp1__ack   = grant1;
    assign resp0__valid = pop && !head;
    assign resp1__valid = pop && head;
    assign resp0__id    = sram_access_resp__id;
    assign resp1__id    = sram_access_resp__id;
    assign resp0__data  = sram_access_resp__data;
    assign resp1__data  = sram_access_resp__data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sram_access_req__valid          <= 1'b0;
            sram_access_req__id             <= '0;
            sram_access_req__read_not_write <= 1'b0;
            sram_access_req__byte_enable    <= '0;
            sram_access_req__address        <= '0;
            sram_access_req__write_data     <= '0;
            wr_ptr                          <= '0;
            rd_ptr                          <= '0;
            order_mem                       <= '0;
            last_grant                      <= 1'b1;
            outstanding                     <= '0;
            protocol_error                  <= 1'b0;
        end else if (clk__enable) begin
            if (push) begin
                sram_access_req__valid          <= 1'b1;
                sram_access_req__id             <= sel_id;
                sram_access_req__read_not_write <= sel_rnw;
                sram_access_req__byte_enable    <= sel_be;
                sram_access_req__address        <= sel_address;
                sram_access_req__write_data     <= sel_write_data;
                order_mem[wr_ptr]               <= grant1;
                wr_ptr                          <= wr_ptr + 1'b1;
                last_grant                      <= grant1;
            end else if (stage_free) begin
                sram_access_req__valid <= 1'b0;
            end

            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            if (push && !pop) begin
                outstanding <= outstanding + 5'd1;
            end else if (pop && !push) begin
                outstanding <= outstanding - 5'd1;
            end

            // a response with nothing outstanding is dropped but remembered
            if (sram_access_resp__valid && fifo_empty) begin
                protocol_error <= 1'b1;
            end
        end
    end
endmodule
